conv_frame_ctrl: RTL
====================

Name: conv_frame_ctrl

Overview:
Frame sequencer for the grayscale/Sobel edge-detection datapath. It tracks the column and row of every decimated pixel entering the grayscale line buffer. It flags when the 3x3 convolution window lies fully inside the image and aligns that flag with the convolution output. It latches the filter-mode switches only at frame boundaries, so the output never changes filter mid-frame, and it reports frames that are too short or too long.

Parameters:
IMG_W, 640, active pixels per line after 2x2 decimation
IMG_H, 480, active lines per frame after decimation
PIPE_LAT, 3, cycles from pixel accept to the matching absolute-value convolution output
CW, 11, width of the column/row counters (must hold IMG_W and IMG_H)

Ports:
iCLK  in  1  pixel clock
iRST  in  1  reset, synchronous, active-high
iFVAL  in  1  frame valid from the camera capture block
iDVAL  in  1  decimated pixel strobe (same strobe that clocks the grayscale line buffer)
iSW  in  1  requested output mode: 1 = edge, 0 = grayscale
iSW1  in  1  requested edge direction: 1 = horizontal, 0 = vertical
oMODE_EDGE  out  1  latched edge/gray select
oMODE_HORZ  out  1  latched horizontal/vertical select
oCOL  out  CW  column of the current accepted pixel
oROW  out  CW  row of the current accepted pixel
oWIN_VAL  out  1  convolution output valid and interior, delayed by PIPE_LAT
oBORDER  out  1  convolution output valid but on the window border, delayed by PIPE_LAT
oSOF  out  1  one-cycle pulse on the first accepted pixel of a frame
oEOF  out  1  one-cycle pulse on the last accepted pixel (IMG_W*IMG_H-th)
oFRAME_ERR  out  1  one-cycle pulse when a frame ends with a wrong pixel count

Behaviour:
- Reset (iRST high on a clock edge): every output is 0, the counters are 0, the delay line is cleared, and the state is WAIT_IDLE. Reset mid-frame abandons the frame with no error pulse.
- States:
  - WAIT_IDLE: wait for iFVAL = 0. This guarantees the block never starts mid-frame after reset.
  - WAIT_SOF: wait for a rising edge of iFVAL. The block keeps its own 1-cycle registered copy of iFVAL. On the rising edge, latch iSW into oMODE_EDGE and iSW1 into oMODE_HORZ, clear the counters, and go to PRIME.
  - PRIME: rows 0 and 1, while the line buffer fills. Move to RUN when the pixel at row 1, column IMG_W-1 is accepted.
  - RUN: rows 2 .. IMG_H-1. Move to DONE when the last pixel is accepted.
  - DONE: wait for iFVAL to fall, then go to WAIT_SOF.
- Pixel accept: a pixel is accepted when iDVAL = 1 in PRIME or RUN.
  - On accept, oCOL/oROW present the pixel's coordinates in the same cycle (combinational from the counters).
  - The counters then advance. The column wraps at IMG_W-1 to 0 and increments the row.
  - iDVAL in WAIT_IDLE, WAIT_SOF or DONE is ignored; no counter moves.
- Frame markers:
  - oSOF = accept at (0,0).
  - oEOF = accept at (IMG_W-1, IMG_H-1).
  - If the accept that raises oEOF arrives in the same cycle iFVAL falls, treat the frame as complete with no error.
- Frame errors:
  - iFVAL falls in PRIME or RUN (short frame): pulse oFRAME_ERR and go to WAIT_SOF.
  - iDVAL = 1 in DONE while iFVAL = 1 (long frame): pulse oFRAME_ERR once per frame, then stay in DONE.
- Window flags:
  - On an accepted pixel (c, r), the 3x3 window centre is (c-1, r-1).
  - interior = (c >= 2) and (r >= 2).
  - The pair {accept & interior, accept & ~interior} enters a PIPE_LAT-deep shift register that advances every cycle.
  - Its tap drives oWIN_VAL and oBORDER, which are mutually exclusive.
- Mode selects: oMODE_EDGE and oMODE_HORZ change only on a start-of-frame event. Toggling iSW/iSW1 mid-frame has no effect until the next frame.
- Arithmetic: unsigned counters with no saturation beyond the wrap; compare against IMG_W-1 and IMG_H-1 as constants.

Decomposition:
- Shared package holds:
  - the state enumeration: WAIT_IDLE, WAIT_SOF, PRIME, RUN, DONE;
  - the counter width CW;
  - the default IMG_W, IMG_H and PIPE_LAT constants.
- One sub-module, valid_delay: a parameterised-depth, 2-bit-wide shift register with synchronous active-high clear, used for the oWIN_VAL/oBORDER alignment.
- The state machine and counters stay in the top module.

Test Plan:
- Reset with iFVAL = 1, then iFVAL low→high, then iDVAL every cycle (IMG_W = 8, IMG_H = 4) -> no activity until iFVAL goes 0 then 1; oSOF on the first accept; oEOF on accept 32; oFRAME_ERR = 0.
- Same frame, observing the flags PIPE_LAT = 3 cycles after each accept -> oWIN_VAL high exactly for accepts with c >= 2 and r >= 2 (12 pulses); oBORDER for the other 20.
- iSW = 1, iSW1 = 0 at SOF, then toggle both mid-frame -> oMODE_EDGE = 1 and oMODE_HORZ = 0 for the whole frame; the new values appear after the next iFVAL rise.
- iFVAL drops after 20 accepts -> oFRAME_ERR pulses one cycle, state returns to WAIT_SOF, no oEOF; the next frame runs normally.
- 35 iDVAL strobes with iFVAL high -> oEOF at accept 32; a single oFRAME_ERR pulse on strobe 33; counters frozen.
- iRST asserted at row 2, column 3 -> all outputs 0 on the next cycle, the delay line is empty, and the block waits for iFVAL low before starting again.

Source files
------------

// File: rtl/conv_frame_ctrl_pkg.sv
// Shared types and defaults for the Sobel frame sequencer.
package conv_frame_ctrl_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    WAIT_SOF,
    PRIME,
    RUN,
    DONE
  } state_e;

  localparam int unsigned CNT_W        = 11;
  localparam int unsigned IMG_W_DEF    = 640;
  localparam int unsigned IMG_H_DEF    = 480;
  localparam int unsigned PIPE_LAT_DEF = 3;

endpackage : conv_frame_ctrl_pkg

// File: rtl/conv_frame_ctrl_valid_delay.sv
// Window-flag alignment: 2-bit shift register of configurable depth.
module valid_delay #(
  parameter int unsigned DEPTH = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] din,
  output logic [1:0] dout
);

  logic [1:0] sr_q [DEPTH];
  logic [1:0] sr_d [DEPTH];

  always_comb begin
    sr_d[0] = din;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      sr_d[i] = sr_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sr_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        sr_q[i] <= sr_d[i];
      end
    end
  end

  assign dout = sr_q[DEPTH-1];

endmodule : valid_delay

// File: rtl/conv_frame_ctrl.sv
// Frame sequencer: pixel coordinates, window flags, mode latching, frame errors.
module conv_frame_ctrl
  import conv_frame_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W    = IMG_W_DEF,
  parameter int unsigned IMG_H    = IMG_H_DEF,
  parameter int unsigned PIPE_LAT = PIPE_LAT_DEF,
  parameter int unsigned CW       = CNT_W
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iFVAL,
  input  logic          iDVAL,
  input  logic          iSW,
  input  logic          iSW1,
  output logic          oMODE_EDGE,
  output logic          oMODE_HORZ,
  output logic [CW-1:0] oCOL,
  output logic [CW-1:0] oROW,
  output logic          oWIN_VAL,
  output logic          oBORDER,
  output logic          oSOF,
  output logic          oEOF,
  output logic          oFRAME_ERR
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] ROW_LAST = CW'(IMG_H - 1);
  localparam logic [CW-1:0] ROW_ONE  = CW'(1);
  localparam logic [CW-1:0] TWO      = CW'(2);

  state_e        state_q, state_d;
  logic          fval_q;
  logic [CW-1:0] col_q, col_d;
  logic [CW-1:0] row_q, row_d;
  logic          mode_edge_q, mode_edge_d;
  logic          mode_horz_q, mode_horz_d;
  logic          long_err_q, long_err_d;

  logic          accept;
  logic          fval_rise;
  logic          col_last;
  logic          row_last;
  logic          sof;
  logic          eof;
  logic          interior;
  logic          frame_err;
  logic [1:0]    flag_in;
  logic [1:0]    flag_out;

  always_comb begin
    accept    = iDVAL && ((state_q == PRIME) || (state_q == RUN));
    fval_rise = iFVAL && !fval_q;
    col_last  = (col_q == COL_LAST);
    row_last  = (row_q == ROW_LAST);
    sof       = accept && (col_q == '0) && (row_q == '0);
    eof       = accept && col_last && row_last;
    interior  = (col_q >= TWO) && (row_q >= TWO);
    flag_in   = {accept && interior, accept && !interior};
  end

  // An EOF accept coinciding with the iFVAL fall is a complete frame,
  // so the EOF branches are tested before the short-frame error.
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    mode_edge_d = mode_edge_q;
    mode_horz_d = mode_horz_q;
    long_err_d  = long_err_q;
    frame_err   = 1'b0;

    if (accept) begin
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end

    case (state_q)
      WAIT_IDLE: begin
        if (!iFVAL) state_d = WAIT_SOF;
      end
      WAIT_SOF: begin
        if (fval_rise) begin
          mode_edge_d = iSW;
          mode_horz_d = iSW1;
          col_d       = '0;
          row_d       = '0;
          long_err_d  = 1'b0;
          state_d     = PRIME;
        end
      end
      PRIME: begin
        if (eof) begin
          state_d = iFVAL ? DONE : WAIT_SOF;
        end else if (!iFVAL) begin
          frame_err = 1'b1;
          state_d   = WAIT_SOF;
        end else if (accept && col_last && (row_q == ROW_ONE)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (eof) begin
          state_d = iFVAL ? DONE : WAIT_SOF;
        end else if (!iFVAL) begin
          frame_err = 1'b1;
          state_d   = WAIT_SOF;
        end
      end
      DONE: begin
        if (!iFVAL) begin
          state_d = WAIT_SOF;
        end else if (iDVAL && !long_err_q) begin
          frame_err  = 1'b1;
          long_err_d = 1'b1;
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= WAIT_IDLE;
      fval_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      mode_edge_q <= 1'b0;
      mode_horz_q <= 1'b0;
      long_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fval_q      <= iFVAL;
      col_q       <= col_d;
      row_q       <= row_d;
      mode_edge_q <= mode_edge_d;
      mode_horz_q <= mode_horz_d;
      long_err_q  <= long_err_d;
    end
  end

  valid_delay #(
    .DEPTH(PIPE_LAT)
  ) u_valid_delay (
    .clk  (iCLK),
    .clr  (iRST),
    .din  (flag_in),
    .dout (flag_out)
  );

  assign oMODE_EDGE = mode_edge_q;
  assign oMODE_HORZ = mode_horz_q;
  assign oCOL       = col_q;
  assign oROW       = row_q;
  assign oWIN_VAL   = flag_out[1];
  assign oBORDER    = flag_out[0];
  assign oSOF       = sof;
  assign oEOF       = eof;
  assign oFRAME_ERR = frame_err;

endmodule : conv_frame_ctrl
